mult_int6b_inv_seq: RTL and testbench

Sequential inverse of the 6-bit signed constant multiplier: a multi-cycle restoring divider. Each transaction takes one 14-bit signed product, divides it by the same compile-time coefficient, and returns the 6-bit signed operand, the remainder, and exact/overflow flags. It sits after the multiplier in self-check and decode paths and uses valid/ready handshakes on both sides.

---
 rtl/mult_int6b_inv_seq.sv | 185 ++++++++++++++++++
 tb/tb_mult_int6b_inv_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mult_int6b_inv_seq.sv
// Sequential signed divide-by-constant: inverse of the 6-bit constant multiplier.
// Restoring divider, one quotient bit per cycle, valid/ready on both sides.
module mult_int6b_inv_seq #(
  parameter int BIT_WIDTH  = 6,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = BIT_WIDTH + COEF_WIDTH,
  parameter int COEF       = 77
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OUT_WIDTH-1:0]  in_prod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIT_WIDTH-1:0]  out_inp,
  output logic [COEF_WIDTH-1:0] out_rem,
  output logic                  out_exact,
  output logic                  out_ovf
);

  localparam int CNT_W = $clog2(OUT_WIDTH + 1);
  localparam int DIV_W = COEF_WIDTH + 1;
  localparam int ABS_C = (COEF < 0) ? -COEF : COEF;

  localparam logic [DIV_W-1:0] DIVISOR = DIV_W'(ABS_C);
  localparam logic             COEF_NEG = (COEF < 0);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_WIDTH);

  localparam logic [OUT_WIDTH-1:0] QPOS_LIM =
    OUT_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
  localparam logic [OUT_WIDTH-1:0] QNEG_LIM =
    OUT_WIDTH'(1 << (BIT_WIDTH - 1));

  localparam logic [BIT_WIDTH-1:0] Q_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] Q_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  mag_q, mag_d;
  logic [COEF_WIDTH-1:0] prem_q, prem_d;
  logic                  dsign_q, dsign_d;
  logic                  qsign_q, qsign_d;
  logic [BIT_WIDTH-1:0]  inp_q, inp_d;
  logic [COEF_WIDTH-1:0] rem_q, rem_d;
  logic                  exact_q, exact_d;
  logic                  ovf_q, ovf_d;

  logic [OUT_WIDTH-1:0]  abs_in;
  logic [DIV_W-1:0]      trial;
  logic [DIV_W-1:0]      diff;
  logic                  qbit;
  logic                  q_ovf;
  logic [BIT_WIDTH-1:0]  q_sat;
  logic [BIT_WIDTH-1:0]  q_low;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = DIV;
      DIV:  if (cnt_q == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // |in_prod|; the most negative value maps to 2^(N-1) without wrapping
  always_comb begin
    abs_in = in_prod;
    if (in_prod[OUT_WIDTH-1]) abs_in = ~in_prod + 1'b1;
  end

  // one restoring step against |COEF|
  always_comb begin
    trial = {prem_q, mag_q[OUT_WIDTH-1]};
    diff  = trial - DIVISOR;
    qbit  = (trial >= DIVISOR);
  end

  // signed, saturated quotient from the finished magnitude
  always_comb begin
    q_low = mag_q[BIT_WIDTH-1:0];
    if (qsign_q) q_ovf = (mag_q > QNEG_LIM);
    else         q_ovf = (mag_q > QPOS_LIM);
    if (q_ovf)        q_sat = qsign_q ? Q_MIN : Q_MAX;
    else if (qsign_q) q_sat = -q_low;
    else              q_sat = q_low;
  end

  always_comb begin
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    prem_d  = prem_q;
    dsign_d = dsign_q;
    qsign_d = qsign_q;
    inp_d   = inp_q;
    rem_d   = rem_q;
    exact_d = exact_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d   = '0;
          mag_d   = abs_in;
          prem_d  = '0;
          dsign_d = in_prod[OUT_WIDTH-1];
          qsign_d = in_prod[OUT_WIDTH-1] ^ COEF_NEG;
        end
      end
      DIV: begin
        if (cnt_q != LAST) begin
          cnt_d  = cnt_q + CNT_W'(1);
          mag_d  = {mag_q[OUT_WIDTH-2:0], qbit};
          prem_d = qbit ? diff[COEF_WIDTH-1:0]
                        : trial[COEF_WIDTH-1:0];
        end else begin
          cnt_d   = '0;
          inp_d   = q_sat;
          rem_d   = dsign_q ? -prem_q : prem_q;
          exact_d = (prem_q == '0);
          ovf_d   = q_ovf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mag_q   <= '0;
      prem_q  <= '0;
      dsign_q <= 1'b0;
      qsign_q <= 1'b0;
      inp_q   <= '0;
      rem_q   <= '0;
      exact_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      prem_q  <= prem_d;
      dsign_q <= dsign_d;
      qsign_q <= qsign_d;
      inp_q   <= inp_d;
      rem_q   <= rem_d;
      exact_q <= exact_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_inp   = inp_q;
  assign out_rem   = rem_q;
  assign out_exact = exact_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mult_int6b_inv_seq.sv
// Bench for mult_int6b_inv_seq: directed and random dividends against an
// integer-division model, with a COEF=-77 instance run in lockstep.
module tb_mult_int6b_inv_seq;

  localparam int BW = 6;
  localparam int CW = 8;
  localparam int OW = BW + CW;
  localparam int CP = 77;
  localparam int CN = -77;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [OW-1:0] in_prod = '0;

  logic          in_ready, out_valid, out_exact, out_ovf;
  logic [BW-1:0] out_inp;
  logic [CW-1:0] out_rem;
  logic          n_in_ready, n_out_valid, n_out_exact, n_out_ovf;
  logic [BW-1:0] n_out_inp;
  logic [CW-1:0] n_out_rem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_int6b_inv_seq #(.COEF(CP)) u_pos (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inp(out_inp), .out_rem(out_rem),
    .out_exact(out_exact), .out_ovf(out_ovf)
  );

  mult_int6b_inv_seq #(.COEF(CN)) u_neg (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_prod(in_prod),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_inp(n_out_inp), .out_rem(n_out_rem),
    .out_exact(n_out_exact), .out_ovf(n_out_ovf)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int p, input int c,
                                output int q, output int r,
                                output int ex, output int ov);
    int t;
    int hi;
    int lo;
    hi = (1 << (BW - 1)) - 1;
    lo = -(1 << (BW - 1));
    t  = p / c;
    r  = p % c;
    ov = (t > hi || t < lo) ? 1 : 0;
    q  = (t > hi) ? hi : ((t < lo) ? lo : t);
    ex = (r == 0) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"}, {n_in_ready, in_ready}, 3);
    chk({tag, ".out_valid"}, {n_out_valid, out_valid}, 0);
    chk({tag, ".outs"},
        {out_inp, out_rem, out_exact, out_ovf,
         n_out_inp, n_out_rem, n_out_exact, n_out_ovf}, 0);
  endtask

  task automatic chk_result(input string tag, input int p);
    int q, r, e, o;
    model(p, CP, q, r, e, o);
    chk({tag, ".inp"}, $signed(out_inp), q);
    chk({tag, ".rem"}, $signed(out_rem), r);
    chk({tag, ".exact"}, out_exact, e);
    chk({tag, ".ovf"}, out_ovf, o);
    model(p, CN, q, r, e, o);
    chk({tag, ".n_valid"}, n_out_valid, 1);
    chk({tag, ".n_inp"}, $signed(n_out_inp), q);
    chk({tag, ".n_rem"}, $signed(n_out_rem), r);
    chk({tag, ".n_flags"}, {n_out_exact, n_out_ovf}, {e[0], o[0]});
  endtask

  task automatic txn(input int p, input int stall, input string tag);
    int n;
    int lat;
    logic [31:0] snap;
    in_prod  = OW'(p);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, ".accept"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    in_prod  = OW'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, lat, OW + 1);
    chk_result(tag, p);
    snap = {14'd0, in_ready, out_valid, out_inp, out_rem,
            out_exact, out_ovf};
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      in_prod  = OW'($urandom);
      step();
      chk({tag, ".hold"},
          {14'd0, in_ready, out_valid, out_inp, out_rem,
           out_exact, out_ovf}, snap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".handoff"}, {out_valid, in_ready}, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    step();
    step();
    chk_reset("reset");
    rst_n = 1'b1;
    step();

    txn(-2464, 0, "m32");
    txn(2387, 0, "p31");
    txn(100, 0, "p100");
    txn(-100, 0, "m100");
    txn(8191, 0, "max");
    txn(-8192, 0, "min");
    txn(1000, 10, "bp");

    in_prod  = OW'(1234);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    step();
    rst_n = 1'b1;
    step();
    txn(0, 0, "zero");

    for (int x = -32; x < 32; x++) begin
      txn(x * CP, int'($urandom_range(0, 3)), "reg");
    end

    for (int i = 0; i < 20; i++) begin
      txn(int'($urandom_range(0, 16383)) - 8192,
          int'($urandom_range(0, 2)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
